// File: rtl/cpm_pkg.sv
// Shared CPM definitions: command/status encodings, controller states and the CPM register map.
package cpm_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_POLL  = 2'd2,
        OP_RSVD  = 2'd3
    } cpm_op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_TIMEOUT = 2'd1,
        ST_ERR     = 2'd2
    } cpm_status_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } cpm_state_e;

    localparam logic [7:0] CPM_ADDR_CTRL     = 8'h00;
    localparam logic [7:0] CPM_ADDR_STATUS   = 8'h04;
    localparam logic [7:0] CPM_ADDR_CLK_CFG  = 8'h08;
    localparam logic [7:0] CPM_ADDR_PWR_CFG  = 8'h0C;
    localparam logic [7:0] CPM_ADDR_PWR_STAT = 8'h10;
    localparam logic [7:0] CPM_ADDR_IRQ_EN   = 8'h14;
    localparam logic [7:0] CPM_ADDR_IRQ_STAT = 8'h18;
    localparam logic [7:0] CPM_ADDR_SCRATCH  = 8'h1C;

    function automatic logic poll_match(input logic [31:0] rdata,
                                        input logic [31:0] expected,
                                        input logic [31:0] mask);
        return ((rdata & mask) == (expected & mask));
    endfunction

endpackage

// File: rtl/cpm_reg_master_if.sv
// Command, response and register-bus signals of the CPM register master.
interface cpm_reg_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [31:0] cmd_mask;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;

    logic        req;
    logic        write_en;
    logic        gnt;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready, gnt, rdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_status, req, write_en, addr, wdata
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready, gnt, rdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_status, req, write_en, addr, wdata
    );
endinterface

// File: rtl/cpm_reg_master.sv
// Register-bus master: runs one WRITE, READ or masked POLL command at a time and returns a response.
//   state    | meaning
//   S_IDLE   | ready for a command
//   S_ACCESS | req held, waiting for gnt
//   S_WAIT   | idle gap between POLL reads (down-counter)
//   S_RESP   | response held until rsp_ready
module cpm_reg_master
    import cpm_pkg::*;
#(
    parameter int POLL_TIMEOUT  = 1024,
    parameter int POLL_INTERVAL = 4
) (
    input logic              clk,
    input logic              rst,
    cpm_reg_master_if.master bus
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(POLL_TIMEOUT);
    localparam logic [7:0]  WAIT_LOAD   = (POLL_INTERVAL == 0) ? 8'd0 : 8'(POLL_INTERVAL - 1);

    cpm_state_e  state_q, state_d;
    cpm_op_e     op_q;
    cpm_op_e     cmd_op;
    cpm_status_e status_q;
    logic [7:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] mask_q;
    logic [31:0] rdata_q;
    logic [15:0] attempts_q;
    logic [7:0]  wait_cnt_q;
    logic        accept;
    logic        grant;
    logic        hit;
    logic        last_try;

    assign cmd_op   = cpm_op_e'(bus.cmd_op);
    assign accept   = (state_q == S_IDLE) && bus.cmd_valid && !rst;
    assign grant    = (state_q == S_ACCESS) && bus.gnt;
    assign hit      = poll_match(bus.rdata, wdata_q, mask_q);
    assign last_try = (attempts_q + 16'd1) == TIMEOUT_CNT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (cmd_op == OP_RSVD) ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (grant) begin
                    if (op_q != OP_POLL || hit || last_try) begin
                        state_d = S_RESP;
                    end else if (POLL_INTERVAL != 0) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 8'd0) begin
                    state_d = S_ACCESS;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= OP_WRITE;
            status_q   <= ST_OK;
            addr_q     <= 8'h00;
            wdata_q    <= 32'h0;
            mask_q     <= 32'h0;
            rdata_q    <= 32'h0;
            attempts_q <= 16'h0;
            wait_cnt_q <= 8'h0;
        end else begin
            if (accept) begin
                op_q       <= cmd_op;
                addr_q     <= bus.cmd_addr;
                wdata_q    <= bus.cmd_wdata;
                mask_q     <= bus.cmd_mask;
                attempts_q <= 16'h0;
                rdata_q    <= 32'h0;
                status_q   <= (cmd_op == OP_RSVD) ? ST_ERR : ST_OK;
            end
            if (grant) begin
                if (op_q == OP_READ) begin
                    rdata_q <= bus.rdata;
                end
                if (op_q == OP_POLL) begin
                    attempts_q <= attempts_q + 16'd1;
                    if (hit) begin
                        rdata_q <= bus.rdata;
                    end else if (last_try) begin
                        rdata_q  <= bus.rdata;
                        status_q <= ST_TIMEOUT;
                    end else begin
                        wait_cnt_q <= WAIT_LOAD;
                    end
                end
            end
            if (state_q == S_WAIT && wait_cnt_q != 8'd0) begin
                wait_cnt_q <= wait_cnt_q - 8'd1;
            end
        end
    end

    // Bus outputs are zero outside ACCESS so the slave never sees stale address/data.
    assign bus.cmd_ready  = (state_q == S_IDLE) && !rst;
    assign bus.req        = (state_q == S_ACCESS);
    assign bus.write_en   = bus.req && (op_q == OP_WRITE);
    assign bus.addr       = bus.req ? addr_q : 8'h00;
    assign bus.wdata      = bus.write_en ? wdata_q : 32'h0;
    assign bus.rsp_valid  = (state_q == S_RESP);
    assign bus.rsp_rdata  = rdata_q;
    assign bus.rsp_status = status_q;

endmodule

// File: doc/cpm_reg_master.md
CPM_REG_MASTER -- requirements
Module: cpm_reg_master

Interface
REQ-001 Parameter POLL_TIMEOUT, 1024, maximum bus reads per POLL command (range 1..65535).
REQ-002 Parameter POLL_INTERVAL, 4, idle cycles between consecutive POLL reads (range 0..255).
REQ-003 Reset rst SHALL be synchronous, active-high; clock clk.
REQ-004 clk  in  1  clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-008 cmd_op  in  2  0=WRITE, 1=READ, 2=POLL, 3=reserved.
REQ-009 cmd_addr  in  8  register address.
REQ-010 cmd_wdata  in  32  write data (WRITE), expected value (POLL).
REQ-011 cmd_mask  in  32  compare mask (POLL only).
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  response consumed when high with rsp_valid.
REQ-014 rsp_rdata  out  32  read data (0 for WRITE and ERR).
REQ-015 rsp_status  out  2  0=OK, 1=TIMEOUT, 2=ERR.
REQ-016 req, write_en  out  1 each  bus request, write qualifier.
REQ-017 gnt  in  1  bus grant; transfer completes in cycle req&&gnt.
REQ-018 addr  out  8; wdata  out  32; rdata  in  32 (valid combinationally in grant cycle).

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, WAIT, RESP.
REQ-020 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready latch op/addr/wdata/mask, clear attempt counter, go ACCESS (op 0..2) or RESP with status ERR (op 3, no bus access).
REQ-021 cmd_ready SHALL be 0 in every state other than IDLE.
REQ-022 ACCESS: req=1; addr, write_en (1 only for WRITE), wdata (latched value for WRITE, 0 otherwise) SHALL be stable until the grant cycle.
REQ-023 Grant cycle, WRITE: go RESP, status OK, rdata 0.
REQ-024 Grant cycle, READ: capture rdata, go RESP, status OK.
REQ-025 Grant cycle, POLL: increment 16-bit attempt counter; if (rdata&mask)==(wdata&mask) capture rdata, go RESP OK; else if attempts==POLL_TIMEOUT capture rdata, go RESP TIMEOUT; else go WAIT (or directly ACCESS when POLL_INTERVAL=0).
REQ-026 WAIT: req=0 for exactly POLL_INTERVAL cycles, then ACCESS.
REQ-027 RESP: rsp_valid=1, rsp_rdata/rsp_status stable; on rsp_ready go IDLE; new command not accepted in the same cycle.
REQ-028 Latency: command accepted cycle T -> req high T+1; grant at T+1 -> rsp_valid high T+2.
REQ-029 req SHALL deassert the cycle after its grant cycle; back-to-back bus accesses only via a new ACCESS entry.
REQ-030 mask=0 POLL SHALL match on first read.

Reset
REQ-031 On rst: state IDLE, req=0, write_en=0, addr=0, wdata=0, rsp_valid=0, rsp_rdata=0, rsp_status=0, cmd_ready=0 during reset cycle then 1, counters 0.
REQ-032 rst asserted mid-ACCESS/WAIT/RESP SHALL abort the command with no response; req low the cycle after the reset edge.

Structure
REQ-033 Shared package cpm_pkg SHALL hold cmd_op and rsp_status enums and the CPM register address constants (0x00..0x1C), shared with the CPM block.
REQ-034 Single module, no sub-module; target 150-250 lines RTL.

Verification
REQ-035 WRITE addr 0x00 wdata 0x1, gnt=req -> one req cycle, write_en=1, addr 0x00, wdata 0x1; rsp_valid 2 cycles after accept, OK, rdata 0.
REQ-036 READ addr 0x08, slave returns 0x00FF1234, gnt delayed 3 cycles -> req held 4 cycles with stable addr, rsp OK rdata 0x00FF1234.
REQ-037 POLL addr 0x10 mask 0x1 expected 0, busy=1 for 3 reads then 0 -> 4 reads separated by 4 idle cycles, rsp OK rdata 0.
REQ-038 POLL never matching, POLL_TIMEOUT=8 -> exactly 8 reads, rsp TIMEOUT with last rdata.
REQ-039 cmd_op=3 with rsp_ready low 5 cycles -> no req, rsp ERR held stable, cmd_ready 0 until consumed.
REQ-040 rst during POLL WAIT -> no response, req 0, cmd_ready 1 the cycle after reset deasserts.
